// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch (I) port, the load/store (D) port and the
//            shared single-port memory bus of mem_port_arbiter.
// Ports    : slave  - arbiter view (takes requests, drives grants, responses
//                     and the memory command; receives memRdata)
//            master - environment view (CPU requesters plus memory model)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch port
  logic          iReq;
  logic [AW-1:0] iAddr;
  logic          iGnt;
  logic          iRvalid;
  logic [DW-1:0] iRdata;
  // Load/store port
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic          dGnt;
  logic          dRvalid;
  logic [DW-1:0] dRdata;
  // Shared memory bus
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
    output iGnt, iRvalid, iRdata, dGnt, dRvalid, dRdata,
           memEn, memWe, memAddr, memWdata
  );

  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWdata, memRdata,
    input  iGnt, iRvalid, iRdata, dGnt, dRvalid, dRdata,
           memEn, memWe, memAddr, memWdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between the CPU fetch
//            path (I) and load/store path (D). At most one access per cycle,
//            D has priority, and a consecutive-denial counter forces an I
//            grant after MAX_WAIT lost cycles. Read data returns one cycle
//            after the grant with a per-port rvalid. Saturating statistics
//            counters track grants and contention.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            bus          - mem_port_arbiter_if.slave (I/D ports, memory bus)
//            iGrantCnt    - saturating count of I grants
//            dGrantCnt    - saturating count of D grants
//            conflictCnt  - saturating count of cycles with both requests
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [CW-1:0]        iGrantCnt,
  output logic [CW-1:0]        dGrantCnt,
  output logic [CW-1:0]        conflictCnt
);

  localparam logic [7:0]    C_WAIT_MAX = 8'(MAX_WAIT);
  localparam logic [CW-1:0] C_CNT_MAX  = '1;

  logic          w_iWin;
  logic          w_dWin;
  logic [7:0]    waitCnt_q, waitCnt_d;
  logic          iRvalid_q, iRvalid_d;
  logic          dRvalid_q, dRvalid_d;
  logic [AW-1:0] lastAddr_q, lastAddr_d;
  logic [DW-1:0] lastWdata_q, lastWdata_d;
  logic [CW-1:0] iCnt_q, iCnt_d;
  logic [CW-1:0] dCnt_q, dCnt_d;
  logic [CW-1:0] cCnt_q, cCnt_d;

  // Winner selection. Gating with rst_n keeps every grant and memory strobe
  // low for the whole time reset is held, not just from the next edge.
  always_comb begin
    w_iWin = 1'b0;
    w_dWin = 1'b0;
    if (rst_n) begin
      if (bus.iReq && (!bus.dReq || (waitCnt_q == C_WAIT_MAX))) begin
        w_iWin = 1'b1;
      end else if (bus.dReq) begin
        w_dWin = 1'b1;
      end
    end
  end

  // Memory command. When idle the address/data hold their last driven value
  // so the bus does not toggle needlessly.
  always_comb begin
    bus.memEn    = w_iWin | w_dWin;
    bus.memWe    = w_dWin & bus.dWe;
    bus.memAddr  = lastAddr_q;
    bus.memWdata = lastWdata_q;
    if (w_dWin) begin
      bus.memAddr  = bus.dAddr;
      bus.memWdata = bus.dWdata;
    end else if (w_iWin) begin
      bus.memAddr  = bus.iAddr;
      bus.memWdata = '0;
    end
  end

  assign bus.iGnt    = w_iWin;
  assign bus.dGnt    = w_dWin;
  assign bus.iRvalid = iRvalid_q;
  assign bus.dRvalid = dRvalid_q;
  assign bus.iRdata  = bus.memRdata;
  assign bus.dRdata  = bus.memRdata;

  assign iGrantCnt   = iCnt_q;
  assign dGrantCnt   = dCnt_q;
  assign conflictCnt = cCnt_q;

  // Next-state logic
  always_comb begin
    // Denial streak: only grows while I is requesting and losing; the
    // forced win at C_WAIT_MAX keeps it from ever passing that value.
    waitCnt_d = waitCnt_q;
    if (!bus.iReq || w_iWin) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != C_WAIT_MAX) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end

    // Fetches are always reads; D reads only when dWe is low.
    iRvalid_d = w_iWin;
    dRvalid_d = w_dWin & ~bus.dWe;

    lastAddr_d  = bus.memAddr;
    lastWdata_d = bus.memWdata;

    iCnt_d = iCnt_q;
    dCnt_d = dCnt_q;
    cCnt_d = cCnt_q;
    if (w_iWin && (iCnt_q != C_CNT_MAX)) begin
      iCnt_d = iCnt_q + 1'b1;
    end
    if (w_dWin && (dCnt_q != C_CNT_MAX)) begin
      dCnt_d = dCnt_q + 1'b1;
    end
    if (bus.iReq && bus.dReq && (cCnt_q != C_CNT_MAX)) begin
      cCnt_d = cCnt_q + 1'b1;
    end
  end

  // State registers. Clearing the rvalid flops drops any response that was
  // in flight when reset arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q   <= '0;
      iRvalid_q   <= 1'b0;
      dRvalid_q   <= 1'b0;
      lastAddr_q  <= '0;
      lastWdata_q <= '0;
      iCnt_q      <= '0;
      dCnt_q      <= '0;
      cCnt_q      <= '0;
    end else begin
      waitCnt_q   <= waitCnt_d;
      iRvalid_q   <= iRvalid_d;
      dRvalid_q   <= dRvalid_d;
      lastAddr_q  <= lastAddr_d;
      lastWdata_q <= lastWdata_d;
      iCnt_q      <= iCnt_d;
      dCnt_q      <= dCnt_d;
      cCnt_q      <= cCnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A main instance
//            (CW=16) and a small-counter instance (CW=4) see identical
//            stimulus; a word-array memory answers the bus, and a reference
//            model predicts grants, responses and counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int CW       = 16;
  localparam int SCW      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) sbus ();

  logic [CW-1:0]  iGrantCnt, dGrantCnt, conflictCnt;
  logic [SCW-1:0] s_iCnt, s_dCnt, s_cCnt;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .iGrantCnt(iGrantCnt), .dGrantCnt(dGrantCnt), .conflictCnt(conflictCnt)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(SCW)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus),
    .iGrantCnt(s_iCnt), .dGrantCnt(s_dCnt), .conflictCnt(s_cCnt)
  );

  assign sbus.iReq     = bus.iReq;
  assign sbus.iAddr    = bus.iAddr;
  assign sbus.dReq     = bus.dReq;
  assign sbus.dWe      = bus.dWe;
  assign sbus.dAddr    = bus.dAddr;
  assign sbus.dWdata   = bus.dWdata;
  assign sbus.memRdata = bus.memRdata;

  // Initial memory contents are a fixed function of the word index.
  function automatic logic [31:0] pat(input int i);
    return {8'hA5, i[7:0], ~i[7:0], 8'h3C};
  endfunction

  // Memory: 256 words; unwritten words read back the pattern.
  bit [DW-1:0] env_mem [256];
  bit          env_wr  [256];
  always @(posedge clk) begin
    if (bus.memEn) begin
      if (bus.memWe) begin
        env_mem[bus.memAddr[9:2]] <= bus.memWdata;
        env_wr[bus.memAddr[9:2]]  <= 1'b1;
      end else begin
        bus.memRdata <= env_wr[bus.memAddr[9:2]] ? env_mem[bus.memAddr[9:2]]
                                                 : pat(int'(bus.memAddr[9:2]));
      end
    end
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int m_wait, m_iCnt, m_dCnt, m_cCnt;
  bit m_pendI, m_pendD;
  logic [31:0] m_dataI, m_dataD;
  logic [31:0] sh [int];
  bit exp_i, exp_d;
  bit s_iGnt, s_dGnt, s_iRv, s_dRv;

  function automatic logic [31:0] sh_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a[9:2]);
    return sh.exists(k) ? sh[k] : pat(k);
  endfunction

  function automatic int satv(input int x, input int w);
    int m;
    m = (1 << w) - 1;
    return (x > m) ? m : x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_iCnt = 0; m_dCnt = 0; m_cCnt = 0;
    m_pendI = 0; m_pendD = 0;
  endtask

  task automatic idle();
    bus.iReq = 0; bus.iAddr = '0;
    bus.dReq = 0; bus.dWe = 0; bus.dAddr = '0; bus.dWdata = '0;
  endtask

  // One checked cycle: inputs are already driven; sample at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    exp_i = bus.iReq && (!bus.dReq || (m_wait >= MAX_WAIT));
    exp_d = bus.dReq && !exp_i;
    s_iGnt = bus.iGnt; s_dGnt = bus.dGnt; s_iRv = bus.iRvalid; s_dRv = bus.dRvalid;
    chk("iGnt", bus.iGnt, exp_i);
    chk("dGnt", bus.dGnt, exp_d);
    chk("memEn", bus.memEn, exp_i || exp_d);
    chk("memWe", bus.memWe, exp_d && bus.dWe);
    if (exp_i) begin
      chk("memAddr_I", bus.memAddr, bus.iAddr);
      chk("memWdata_I", bus.memWdata, 0);
    end
    if (exp_d) begin
      chk("memAddr_D", bus.memAddr, bus.dAddr);
      if (bus.dWe) chk("memWdata_D", bus.memWdata, bus.dWdata);
    end
    chk("iRvalid", bus.iRvalid, m_pendI);
    chk("dRvalid", bus.dRvalid, m_pendD);
    if (m_pendI) chk("iRdata", bus.iRdata, m_dataI);
    if (m_pendD) chk("dRdata", bus.dRdata, m_dataD);
    chk("iGrantCnt", iGrantCnt, satv(m_iCnt, CW));
    chk("dGrantCnt", dGrantCnt, satv(m_dCnt, CW));
    chk("conflictCnt", conflictCnt, satv(m_cCnt, CW));
    chk("sat_iGrantCnt", s_iCnt, satv(m_iCnt, SCW));
    chk("sat_dGrantCnt", s_dCnt, satv(m_dCnt, SCW));
    chk("sat_conflictCnt", s_cCnt, satv(m_cCnt, SCW));
    // advance model
    m_pendI = exp_i;
    if (exp_i) m_dataI = sh_rd(bus.iAddr);
    m_pendD = exp_d && !bus.dWe;
    if (m_pendD) m_dataD = sh_rd(bus.dAddr);
    if (exp_d && bus.dWe) sh[int'(bus.dAddr[9:2])] = bus.dWdata;
    if (bus.iReq && bus.dReq) m_cCnt++;
    if (exp_i) m_iCnt++;
    if (exp_d) m_dCnt++;
    m_wait = (bus.iReq && !exp_i) ? m_wait + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset immediately (caller positions it mid-cycle), checks that
  // everything drops at once, then releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_iGnt", bus.iGnt, 0);
    chk("rst_dGnt", bus.dGnt, 0);
    chk("rst_memEn", bus.memEn, 0);
    chk("rst_memWe", bus.memWe, 0);
    chk("rst_iRvalid", bus.iRvalid, 0);
    chk("rst_dRvalid", bus.dRvalid, 0);
    chk("rst_iGrantCnt", iGrantCnt, 0);
    chk("rst_dGrantCnt", dGrantCnt, 0);
    chk("rst_conflictCnt", conflictCnt, 0);
    chk("rst_sat_iGrantCnt", s_iCnt, 0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          iReq;
    logic [31:0] iAddr;
    bit          dReq;
    bit          dWe;
    logic [31:0] dAddr;
    logic [31:0] dWd;
    bit          eiG;
    bit          edG;
    bit          eiRv;
    bit          edRv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da,
                              logic [31:0] wd, bit eig, bit edg, bit eirv, bit edrv);
    vec_t v;
    v.iReq = ir; v.iAddr = ia; v.dReq = dr; v.dWe = dw; v.dAddr = da; v.dWd = wd;
    v.eiG = eig; v.edG = edg; v.eiRv = eirv; v.edRv = edrv;
    tbl.push_back(v);
  endfunction

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the table: lone fetch after reset, D write then read,
    // contention, then starvation with D held for 10 cycles.
    add(1, 32'h100, 0, 0, 0,     0,            1, 0, 0, 0);
    add(0, 0,       0, 0, 0,     0,            0, 0, 1, 0);
    add(0, 0,       1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 0, 0);
    add(0, 0,       1, 0, 32'h40, 0,            0, 1, 0, 0);
    add(0, 0,       0, 0, 0,     0,            0, 0, 0, 1);
    add(1, 32'h104, 1, 0, 32'h48, 0,           0, 1, 0, 0);
    add(1, 32'h104, 0, 0, 0,     0,            1, 0, 0, 1);
    add(0, 0,       0, 0, 0,     0,            0, 0, 1, 0);
    add(1, 32'h108, 1, 0, 32'h4C, 0,           0, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 32'h108, 1, 0, 32'h4C, 0, 0, 1, 0, 1);
    add(1, 32'h108, 1, 0, 32'h4C, 0,           1, 0, 0, 1);
    add(1, 32'h108, 1, 0, 32'h4C, 0,           0, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 32'h108, 1, 0, 32'h4C, 0, 0, 1, 0, 1);
    add(1, 32'h108, 1, 0, 32'h4C, 0,           1, 0, 0, 1);
    add(0, 0,       0, 0, 0,     0,            0, 0, 1, 0);

    // Reset with both requests high, asserted mid-cycle.
    bus.iReq = 1; bus.iAddr = 32'h200; bus.dReq = 1; bus.dWe = 1;
    bus.dAddr = 32'h80; bus.dWdata = 32'h12345678;
    #2;
    do_reset();

    foreach (tbl[n]) begin
      bus.iReq = tbl[n].iReq; bus.iAddr = tbl[n].iAddr;
      bus.dReq = tbl[n].dReq; bus.dWe = tbl[n].dWe;
      bus.dAddr = tbl[n].dAddr; bus.dWdata = tbl[n].dWd;
      step();
      chk($sformatf("tbl%0d_iGnt", n), s_iGnt, tbl[n].eiG);
      chk($sformatf("tbl%0d_dGnt", n), s_dGnt, tbl[n].edG);
      chk($sformatf("tbl%0d_iRvalid", n), s_iRv, tbl[n].eiRv);
      chk($sformatf("tbl%0d_dRvalid", n), s_dRv, tbl[n].edRv);
    end
    chk("conflictCnt_after_table", conflictCnt, 11);

    // Reset while a D read is in flight: no dRvalid after release.
    bus.dReq = 1; bus.dWe = 0; bus.dAddr = 32'h40;
    @(negedge clk);
    chk("midread_dGnt", bus.dGnt, 1);
    #2;
    do_reset();
    step();
    chk("midread_no_dRvalid", s_dRv, 0);
    step();

    // Saturation: 20 lone fetches; the 4-bit counter must stop at 15.
    for (int k = 0; k < 20; k++) begin
      bus.iReq = 1; bus.iAddr = {22'd0, 8'(k), 2'b00};
      step();
    end
    idle();
    step();
    chk("sat_iGrantCnt_15", s_iCnt, 15);
    chk("iGrantCnt_20", iGrantCnt, 20);

    // Randomized traffic honouring the hold-until-grant protocol.
    idle();
    for (int n = 0; n < 600; n++) begin
      if (!bus.iReq || exp_i) begin
        bus.iReq = 1'($urandom_range(0, 1));
        bus.iAddr = {22'd0, 8'($urandom), 2'b00};
      end else if ($urandom_range(0, 7) == 0) begin
        bus.iReq = 0;
      end
      if (!bus.dReq || exp_d) begin
        bus.dReq = ($urandom_range(0, 3) != 0);
        bus.dWe = 1'($urandom_range(0, 1));
        bus.dAddr = {22'd0, 4'd0, 4'($urandom), 2'b00};
        bus.dWdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.dReq = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing one single-port synchronous memory between the CPU's instruction-fetch path (I port) and load/store path (D port). It sits between the cpu core and its unified instruction/data memory. It grants at most one access per cycle, with data priority plus a starvation guard for fetches, and routes read data back to the winner one cycle later. Saturating grant/conflict counters support testbench profiling.

## Interface
Parameters:
- AW, 32: address width (byte address, passed through unchanged).
- DW, 32: data width.
- MAX_WAIT, 4: consecutive denied I-request cycles before I is forced to win; legal range 1..255.
- CW, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iReq  in  1  fetch request; addr held stable until iGnt.
- iAddr  in  AW  fetch address.
- iGnt  out  1  fetch accepted this cycle (combinational).
- iRvalid  out  1  iRdata valid (registered).
- iRdata  out  DW  fetch data.
- dReq  in  1  data request; dWe/dAddr/dWdata held stable until dGnt.
- dWe  in  1  1 = write, 0 = read.
- dAddr  in  AW  data address.
- dWdata  in  DW  write data.
- dGnt  out  1  data access accepted this cycle (combinational).
- dRvalid  out  1  dRdata valid, reads only (registered).
- dRdata  out  DW  load data.
- memEn  out  1  memory access strobe.
- memWe  out  1  memory write enable.
- memAddr  out  AW  memory address.
- memWdata  out  DW  memory write data.
- memRdata  in  DW  memory read data, valid cycle after memEn with memWe=0.
- iGrantCnt  out  CW  saturating count of I grants.
- dGrantCnt  out  CW  saturating count of D grants.
- conflictCnt  out  CW  saturating count of cycles with iReq and dReq both high.

## Operation
- Winner selection each cycle (combinational):
  - only one req high: that port wins.
  - both high: D wins, unless waitCnt == MAX_WAIT, in which case I wins.
  - neither: no grant, memEn=0, memWe=0, memAddr/memWdata hold last driven value (don't care).
- Winner's command drives memEn=1, memAddr, memWe (0 for I), memWdata (0 for I); matching gnt asserted. Memory commits on the rising edge ending that cycle.
- waitCnt (8-bit internal): +1 on each cycle iReq=1 and iGnt=0; cleared on iGnt or iReq=0; never exceeds MAX_WAIT.
- Response owner register: on edge after a read grant, owner set to I or D; corresponding rvalid high for exactly one cycle. Writes produce no rvalid; dGnt is the write completion.
- iRdata and dRdata both driven from memRdata; only meaningful with own rvalid.
- Back-to-back grants allowed; a new grant may coincide with the previous grant's rvalid cycle.
- Counters: increment at edge per event, saturate at 2^CW-1, never wrap.

## Timing
- Reset (rst_n low, any time, async): iRvalid=dRvalid=0, waitCnt=0, all counters 0. Pending response dropped—no rvalid after reset release for a pre-reset grant. Combinational gnt/mem outputs forced 0 while rst_n low.
- Grant latency: 0 cycles if uncontested; D contested: 0; I contested: ≤ MAX_WAIT cycles of denial before forced win.
- Read latency: rvalid exactly 1 cycle after gnt cycle.
- Requester deasserting req without gnt is legal; no access issued.
- Simultaneous reads by both: D served cycle N (dRvalid N+1), I served N+1 (iRvalid N+2) if D's req drops; otherwise per starvation rule.
- Fairness guarantee: with dReq continuously high, I is granted at least once every MAX_WAIT+1 cycles.

## Test plan
- Reset: drive req lines, assert rst_n=0 mid-cycle -> gnt, rvalid, counters all 0 immediately; release, iReq alone at 0x100 -> iGnt same cycle, iRvalid next cycle with memory word at 0x100.
- Lone D write then read: write 0xDEADBEEF to 0x40, read 0x40 next cycle -> dGnt both cycles, no dRvalid after write, dRvalid with 0xDEADBEEF after read.
- Contention: iReq and dReq (read) high same cycle -> dGnt cycle N, iGnt cycle N+1, dRvalid N+1, iRvalid N+2; conflictCnt=1.
- Starvation: dReq held high 10 cycles with MAX_WAIT=4, iReq high -> iGnt exactly in cycle 5 (after 4 denials), dGnt absent that cycle, waitCnt cleared.
- Reset mid-read: grant a D read, pull rst_n low before next edge -> no dRvalid after release.
- Saturation: CW=4, 20 lone I grants -> iGrantCnt stops at 15.
